// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the character FIFO between the UART engines and the
//   host side.
//   - FIFO_DEF_WIDTH / FIFO_DEF_DEPTH : default word width and entry count
//   - fifo_status_t                   : bundle of the occupancy flags
//   - ptr_w(depth)                    : pointer width for a given depth
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
//   Wrapping pointer register. It counts modulo 2**W, so a power-of-2 depth
//   wraps from DEPTH-1 back to 0 without any compare logic.
//   Ports:
//     clk   in  1  clock, rising edge
//     reset in  1  asynchronous, active-low reset (pointer -> 0)
//     clr   in  1  synchronous clear (pointer -> 0), wins over inc
//     inc   in  1  advance the pointer by one
//     ptr   out W  current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_thresh.sv
// -----------------------------------------------------------------------------
// sync_fifo_thresh
//   Single-clock first-word-fall-through FIFO with exact occupancy count,
//   almost-full / almost-empty thresholds and a synchronous flush.
//   Optional feature: define FIFO_ERR_FLAGS_EN to build sticky overflow /
//   underflow flags; without it both outputs are constant 0.
//   Ports:
//     clk          in   1              clock, rising edge
//     reset        in   1              asynchronous, active-low reset
//     clear        in   1              synchronous flush, overrides wr_en/rd_en
//     wr_en        in   1              write request
//     din          in   DATA_WIDTH     write data
//     rd_en        in   1              read request, pops the current dout
//     dout         out  DATA_WIDTH     head entry, 0 when empty
//     full         out  1              count == DEPTH
//     empty        out  1              count == 0
//     almost_full  out  1              count >= AF_LEVEL
//     almost_empty out  1              count <= AE_LEVEL
//     count        out  clog2(DEPTH)+1 occupancy 0..DEPTH
//     overflow     out  1              sticky: a write was refused
//     underflow    out  1              sticky: a read was refused
//
//   Handshake: a write is taken at the rising edge when wr_en=1 and the FIFO is
//   not full, or is full but a read is taken in the same cycle; a read is taken
//   when rd_en=1 and the FIFO is not empty. Both decisions use the registered
//   state before the edge. Refused requests leave pointers, count and memory
//   untouched. clear=1 takes neither request.
// -----------------------------------------------------------------------------
module sync_fifo_thresh
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  fifo_status_t          status;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode straight from the registered count, so they are glitch-free
  // relative to the clock and carry no extra latency.
  assign status.full         = (count == CW'(DEPTH));
  assign status.empty        = (count == '0);
  assign status.almost_full  = (count >= CW'(AF_LEVEL));
  assign status.almost_empty = (count <= CW'(AE_LEVEL));

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // A write into a full FIFO is fine when the head is popped at the same edge:
  // the freed slot is exactly the one wr_ptr points at.
  assign wr_ok  = wr_en & (~status.full | rd_en);
  assign rd_ok  = rd_en & ~status.empty;
  assign wr_acc = wr_ok & ~clear;
  assign rd_acc = rd_ok & ~clear;

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; empty masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = status.empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & ~wr_ok) overflow  <= 1'b1;
      if (rd_en & ~rd_ok) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_thresh
//   Self-checking bench for sync_fifo_thresh (DEPTH=16, AF=12, AE=2).
//   A reference occupancy model and an expected-data queue are updated as
//   stimulus is driven; popped words, count, flags and error flags are
//   compared against them every cycle.
// -----------------------------------------------------------------------------
module tb_sync_fifo_thresh;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          rd_en;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  logic [W-1:0] exp_q[$];
  int           mdl_count;
  logic         mdl_ovf;
  logic         mdl_unf;
  logic [W-1:0] last_pop;
  int           checks;
  int           errors;

  sync_fifo_thresh #(
    .DATA_WIDTH (W),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus. Expected acceptance comes from the bench model;
  // popped data is compared before the edge, state after it.
  task automatic do_cycle(input logic we, input logic re, input logic [W-1:0] d);
    logic         wok;
    logic         rok;
    logic [W-1:0] e;
    logic [CW-1:0] exp_cnt;
    logic [3:0]   exp_flags;
    wr_en = we;
    rd_en = re;
    din   = d;
    wok = we && ((mdl_count < DEPTH) || re);
    rok = re && (mdl_count > 0);
    #1;
    if (rok) begin
      e = exp_q.pop_front();
      last_pop = e;
      checks++;
      if (dout !== e) begin
        errors++;
        $display("FAIL pop_data: dout=%h expected=%h", dout, e);
      end
    end
    if (wok) exp_q.push_back(d);
    if (wok && !rok) mdl_count++;
    if (rok && !wok) mdl_count--;
`ifdef FIFO_ERR_FLAGS_EN
    if (we && !wok) mdl_ovf = 1'b1;
    if (re && !rok) mdl_unf = 1'b1;
`endif
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_cnt   = CW'(mdl_count);
    exp_flags = {mdl_count == DEPTH, mdl_count == 0, mdl_count >= AF, mdl_count <= AE};
    checks++;
    if (count !== exp_cnt) begin
      errors++;
      $display("FAIL count: got %0d expected %0d", count, exp_cnt);
    end
    checks++;
    if ({full, empty, almost_full, almost_empty} !== exp_flags) begin
      errors++;
      $display("FAIL flags(f,e,af,ae): got %b expected %b",
               {full, empty, almost_full, almost_empty}, exp_flags);
    end
    checks++;
    if ({overflow, underflow} !== {mdl_ovf, mdl_unf}) begin
      errors++;
      $display("FAIL err_flags(ovf,unf): got %b expected %b",
               {overflow, underflow}, {mdl_ovf, mdl_unf});
    end
  endtask

  task automatic do_clear(input logic we, input logic [W-1:0] d);
    clear = 1'b1;
    wr_en = we;
    din   = d;
    @(posedge clk);
    #1;
    clear = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    mdl_count = 0;
    mdl_ovf   = 1'b0;
    mdl_unf   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #12;
    checks++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      errors++;
      $display("FAIL reset_flags(e,f,ae,af,ovf,unf): got %b expected 101000",
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    checks++;
    if (count !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_count_dout: count=%0d dout=%h expected 0/00", count, dout);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_fill;
    for (int i = 1; i <= DEPTH; i++) begin
      do_cycle(1'b1, 1'b0, W'(i));
      checks++;
      if (almost_full !== (i >= AF)) begin
        errors++;
        $display("FAIL fill_almost_full after write %0d: got %b expected %b",
                 i, almost_full, (i >= AF));
      end
    end
    checks++;
    if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d expected 1/%0d", full, count, DEPTH);
    end
    // 17th write must be refused
    do_cycle(1'b1, 1'b0, 8'hEE);
  endtask

  task automatic test_drain;
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (last_pop !== W'(i + 1)) begin
        errors++;
        $display("FAIL drain_order: popped %h expected %h", last_pop, W'(i + 1));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: empty=%b expected 1", empty);
    end
    // extra read must be refused
    do_cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_full_rw;
    for (int i = 1; i <= DEPTH; i++) do_cycle(1'b1, 1'b0, W'(8'h30 + i));
    do_cycle(1'b1, 1'b1, 8'hAA);
    checks++;
    if (count !== CW'(DEPTH) || dout !== 8'h32) begin
      errors++;
      $display("FAIL full_rw: count=%0d dout=%h expected %0d/32", count, dout, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (last_pop !== 8'hAA) begin
      errors++;
      $display("FAIL full_rw_last: last popped %h expected aa", last_pop);
    end
  endtask

  task automatic test_empty_rw;
    do_cycle(1'b1, 1'b1, 8'h55);
    checks++;
    if (count !== CW'(1) || dout !== 8'h55) begin
      errors++;
      $display("FAIL empty_rw: count=%0d dout=%h expected 1/55", count, dout);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_clear_wrap;
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, W'(8'h60 + i));
    do_clear(1'b1, 8'h99);
    checks++;
    if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear: count=%0d empty=%b ovf=%b unf=%b expected 0/1/0/0",
               count, empty, overflow, underflow);
    end
    // stream 20 words at occupancy 1 so both pointers wrap
    for (int i = 0; i < 20; i++) do_cycle(1'b1, (i > 0), W'(8'h80 + i));
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (last_pop !== 8'h93 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_last: popped %h empty=%b expected 93/1", last_pop, empty);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
               W'($urandom_range(0, 255)));
    end
    while (mdl_count > 0) do_cycle(1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mdl_count = 0;
    mdl_ovf   = 1'b0;
    mdl_unf   = 1'b0;
    last_pop  = '0;
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_clear_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
